// File: rtl/cell_buffer_pkg.sv
// Shared grid constants, state encoding and cell addressing helpers for the cell buffer.
package cell_buffer_pkg;

  localparam int WIDTH    = 20;
  localparam int HEIGHT   = 15;
  localparam int B_WIDTH  = 5;
  localparam int B_HEIGHT = 4;
  localparam int B_VGA    = 4;

  localparam int RGB_W  = 3 * B_VGA;
  localparam int CELLS  = WIDTH * HEIGHT;
  localparam int CNT_W  = $clog2(CELLS + 1);
  localparam int ADDR_W = $clog2(CELLS);

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Linear cell address y*WIDTH+x, computed at full address width so the product never truncates.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [B_WIDTH-1:0]  x,
                                                  input logic [B_HEIGHT-1:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction

  function automatic logic in_grid(input logic [B_WIDTH-1:0]  x,
                                   input logic [B_HEIGHT-1:0] y);
    return (x < B_WIDTH'(WIDTH)) && (y < B_HEIGHT'(HEIGHT));
  endfunction

endpackage

// File: rtl/cell_ram.sv
// Dual-bank cell colour store: synchronous write port and registered read port.
// The address MSB selects the bank; each bank holds CELLS entries back to back.
module cell_ram
  import cell_buffer_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W:0]   waddr_i,
  input  logic [RGB_W-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W:0]   raddr_i,
  output logic [RGB_W-1:0]  rdata_o
);

  logic [RGB_W-1:0] mem_q [0:2*CELLS-1];
  logic [RGB_W-1:0] rdata_q;

  // Bank 1 starts right after bank 0 so the array stays exactly 2*CELLS deep.
  function automatic logic [ADDR_W:0] row(input logic [ADDR_W:0] a);
    logic [ADDR_W:0] low;
    low = {1'b0, a[ADDR_W-1:0]};
    return a[ADDR_W] ? low + (ADDR_W+1)'(CELLS) : low;
  endfunction

  // Write and registered read; a same-cycle read sees the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[row(waddr_i)] <= wdata_i;
    if (re_i) rdata_q <= mem_q[row(raddr_i)];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cell_buffer.sv
// Double-buffered cell grid: captures one frame of cell writes into the back bank,
// commits it on an update edge and serves the committed grid through a read port.
module cell_buffer
  import cell_buffer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [RGB_W-1:0]    cell_rgb,
  input  logic [B_WIDTH-1:0]  cell_x,
  input  logic [B_HEIGHT-1:0] cell_y,
  input  logic                cell_en,
  input  logic                update,
  input  logic [RGB_W-1:0]    background,
  input  logic [B_WIDTH-1:0]  rd_x,
  input  logic [B_HEIGHT-1:0] rd_y,
  input  logic                rd_en,
  output logic [RGB_W-1:0]    rd_rgb,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    cell_count,
  output logic                frame_done,
  output logic                err
);

  localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);

  logic              en_q, upd_q;
  logic              front_q, front_d;
  logic [RGB_W-1:0]  bg_q, bg_d;
  logic [CELLS-1:0]  vld0_q, vld0_d, vld1_q, vld1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  state_t            state_q, state_d;
  logic              rd_valid_q, use_bg_q;
  logic [RGB_W-1:0]  bg_rd_q;

  logic              wr_edge, upd_edge, wr_in, rd_in, front_hit, ram_we;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [RGB_W-1:0]  ram_rdata;

  assign wr_edge   = cell_en & ~en_q;
  assign upd_edge  = update & ~upd_q;
  assign wr_addr   = cell_addr(cell_x, cell_y);
  assign wr_in     = in_grid(cell_x, cell_y);
  assign rd_addr   = cell_addr(rd_x, rd_y);
  assign rd_in     = in_grid(rd_x, rd_y);
  assign front_hit = rd_in & (front_q ? vld1_q[rd_addr] : vld0_q[rd_addr]);

  // Swap first, then apply the write to whichever bank is back after the swap.
  always_comb begin
    front_d = front_q;
    bg_d    = bg_q;
    vld0_d  = vld0_q;
    vld1_d  = vld1_q;
    cnt_d   = cnt_q;
    done_d  = done_q | (cnt_q == CELLS_C);
    err_d   = err_q;
    state_d = state_q;
    ram_we  = 1'b0;
    if (upd_edge) begin
      front_d = ~front_q;
      bg_d    = background;
      if (front_q) vld1_d = '0;
      else         vld0_d = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      state_d = ACTIVE;
    end
    if (wr_edge) begin
      if (wr_in) begin
        ram_we = 1'b1;
        if (front_d) begin
          if (!vld0_d[wr_addr]) begin
            vld0_d[wr_addr] = 1'b1;
            cnt_d           = cnt_d + CNT_W'(1);
          end
        end else begin
          if (!vld1_d[wr_addr]) begin
            vld1_d[wr_addr] = 1'b1;
            cnt_d           = cnt_d + CNT_W'(1);
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Frame-side control state: strobe history, bank select, masks, progress and FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q    <= 1'b0;
      upd_q   <= 1'b0;
      front_q <= 1'b0;
      bg_q    <= '0;
      vld0_q  <= '0;
      vld1_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      state_q <= EMPTY;
    end else begin
      en_q    <= cell_en;
      upd_q   <= update;
      front_q <= front_d;
      bg_q    <= bg_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  // Read-side selection: decide at request time whether the answer is RAM data or background.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      use_bg_q   <= 1'b1;
      bg_rd_q    <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        use_bg_q <= (state_q == EMPTY) | ~front_hit;
        bg_rd_q  <= bg_q;
      end
    end
  end

  cell_ram u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i ({~front_d, wr_addr}),
    .wdata_i (cell_rgb),
    .re_i    (rd_en & rd_in),
    .raddr_i ({front_q, rd_addr}),
    .rdata_o (ram_rdata)
  );

  assign rd_rgb     = use_bg_q ? bg_rd_q : ram_rdata;
  assign rd_valid   = rd_valid_q;
  assign cell_count = cnt_q;
  assign frame_done = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cell_buffer.sv
// Randomized self-checking bench for cell_buffer against a grid-level reference model.
module tb_cell_buffer;
  import cell_buffer_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [RGB_W-1:0]    cell_rgb = '0;
  logic [B_WIDTH-1:0]  cell_x = '0;
  logic [B_HEIGHT-1:0] cell_y = '0;
  logic                cell_en = 1'b0;
  logic                update = 1'b0;
  logic [RGB_W-1:0]    background = '0;
  logic [B_WIDTH-1:0]  rd_x = '0;
  logic [B_HEIGHT-1:0] rd_y = '0;
  logic                rd_en = 1'b0;
  logic [RGB_W-1:0]    rd_rgb;
  logic                rd_valid;
  logic [CNT_W-1:0]    cell_count;
  logic                frame_done;
  logic                err;

  cell_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .cell_rgb   (cell_rgb),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .cell_en    (cell_en),
    .update     (update),
    .background (background),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_en      (rd_en),
    .rd_rgb     (rd_rgb),
    .rd_valid   (rd_valid),
    .cell_count (cell_count),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: committed grid and grid under construction, -1 marks an unwritten cell.
  int m_front [CELLS];
  int m_back  [CELLS];
  int m_bg, m_cnt, m_rgb;
  bit m_done, m_err, m_active, m_en_prev, m_upd_prev, m_rv;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_front[i]) m_front[i] = -1;
    foreach (m_back[i])  m_back[i]  = -1;
    m_bg = 0; m_cnt = 0; m_rgb = 0;
    m_done = 0; m_err = 0; m_active = 0;
    m_en_prev = 0; m_upd_prev = 0; m_rv = 0;
  endtask

  task automatic model_step();
    bit ee, ue;
    int x, y, a;
    ee = cell_en && !m_en_prev;
    ue = update && !m_upd_prev;
    // reads see the grid as committed before this edge
    if (rd_en) begin
      x = int'(rd_x); y = int'(rd_y);
      m_rv = 1;
      if (!m_active || x >= WIDTH || y >= HEIGHT) m_rgb = m_bg;
      else if (m_front[y*WIDTH+x] < 0)            m_rgb = m_bg;
      else                                        m_rgb = m_front[y*WIDTH+x];
    end else begin
      m_rv = 0;
    end
    m_done = m_done || (m_cnt == CELLS);
    if (ue) begin
      m_front = m_back;
      foreach (m_back[i]) m_back[i] = -1;
      m_bg = int'(background);
      m_cnt = 0; m_done = 0; m_err = 0; m_active = 1;
    end
    if (ee) begin
      x = int'(cell_x); y = int'(cell_y);
      if (x < WIDTH && y < HEIGHT) begin
        a = y*WIDTH + x;
        if (m_back[a] < 0) m_cnt++;
        m_back[a] = int'(cell_rgb);
      end else begin
        m_err = 1;
      end
    end
    m_en_prev  = cell_en;
    m_upd_prev = update;
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    chk("rd_valid",   int'(rd_valid),   int'(m_rv));
    chk("rd_rgb",     int'(rd_rgb),     m_rgb);
    chk("cell_count", int'(cell_count), m_cnt);
    chk("frame_done", int'(frame_done), int'(m_done));
    chk("err",        int'(err),        int'(m_err));
  endtask

  task automatic wr(input int x, input int y, input int c);
    cell_x = B_WIDTH'(x); cell_y = B_HEIGHT'(y); cell_rgb = RGB_W'(c);
    cell_en = 1'b1; step();
    cell_en = 1'b0; step();
  endtask

  task automatic upd(input int bg);
    background = RGB_W'(bg);
    update = 1'b1; step();
    update = 1'b0; step();
  endtask

  task automatic rd(input int x, input int y);
    rd_x = B_WIDTH'(x); rd_y = B_HEIGHT'(y);
    rd_en = 1'b1; step();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    cell_en = 1'b0; update = 1'b0; rd_en = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_rd_rgb",     int'(rd_rgb),     0);
    chk("rst_rd_valid",   int'(rd_valid),   0);
    chk("rst_cell_count", int'(cell_count), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_err",        int'(err),        0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  int hold_c;

  initial begin
    #3;
    do_reset();

    // read with nothing committed yet
    rd(0, 0);
    chk("t1_valid", int'(rd_valid), 1);
    chk("t1_rgb",   int'(rd_rgb),   'h000);
    chk("t1_count", int'(cell_count), 0);

    // single cell committed, neighbour falls back to background
    upd('hFFF);
    wr(3, 2, 'hA5C);
    upd('hFFF);
    rd(3, 2);
    chk("t2_written", int'(rd_rgb), 'hA5C);
    chk("t2_written_vld", int'(rd_valid), 1);
    rd(4, 2);
    chk("t2_background", int'(rd_rgb), 'hFFF);

    // full frame
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++)
        wr(x, y, int'($urandom_range(0, 'hFFF)));
    chk("t3_count", int'(cell_count), CELLS);
    chk("t3_done",  int'(frame_done), 1);
    upd('h123);
    for (int i = 0; i < 12; i++) rd(int'($urandom_range(0, WIDTH-1)), int'($urandom_range(0, HEIGHT-1)));

    // held strobe counts once
    hold_c = 'h5A5;
    cell_x = 5'd7; cell_y = 4'd7; cell_rgb = RGB_W'(hold_c); cell_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    cell_en = 1'b0; step();
    chk("t3_hold_count", int'(cell_count), 1);

    // out-of-range writes
    wr(20, 0, 'h111);
    chk("t4_err_x",   int'(err), 1);
    chk("t4_count_x", int'(cell_count), 1);
    wr(0, 15, 'h222);
    chk("t4_count_y", int'(cell_count), 1);
    upd('h000);
    chk("t4_err_clear", int'(err), 0);

    // update, write and read of the old front in the same cycle
    wr(5, 5, 'h0F0);
    update = 1'b1; background = 12'h321;
    cell_en = 1'b1; cell_x = 5'd9; cell_y = 4'd9; cell_rgb = 12'hBEE;
    rd_en = 1'b1; rd_x = 5'd7; rd_y = 4'd7;
    step();
    update = 1'b0; cell_en = 1'b0; rd_en = 1'b0;
    chk("t5_old_front", int'(rd_rgb), hold_c);
    chk("t5_count",     int'(cell_count), 1);
    step();
    upd('h456);
    rd(9, 9);
    chk("t5_new_write", int'(rd_rgb), 'hBEE);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cell_en    = 1'($urandom_range(0, 1));
      update     = ($urandom_range(0, 39) == 0);
      background = RGB_W'($urandom);
      cell_x     = B_WIDTH'($urandom_range(0, 22));
      cell_y     = B_HEIGHT'($urandom_range(0, 15));
      cell_rgb   = RGB_W'($urandom);
      rd_en      = 1'($urandom_range(0, 1));
      rd_x       = B_WIDTH'($urandom_range(0, 22));
      rd_y       = B_HEIGHT'($urandom_range(0, 15));
      step();
    end
    cell_en = 1'b0; update = 1'b0; rd_en = 1'b0;
    step();

    // reset in the middle of a frame
    upd('hABC);
    for (int i = 0; i < 100; i++) wr(i % WIDTH, i / WIDTH, int'($urandom_range(0, 'hFFF)));
    chk("t6_count_pre", int'(cell_count), 100);
    do_reset();
    rd(0, 0);
    chk("t6_rd_after_rst",  int'(rd_rgb),   'h000);
    chk("t6_vld_after_rst", int'(rd_valid), 1);
    upd('h0F0);
    rd(0, 0);
    chk("t6_discarded", int'(rd_rgb), 'h0F0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
